tilemap_read_arbiter: RTL
=========================

// Module: tilemap_read_arbiter
// PURPOSE
//  Shares the single read port of the tilemap memory (4-bit tile codes) among three requesters.
//  Port 0 is the background tile renderer. Ports 1-2 are background-collision detectors
//  (player, enemy).
//  Each requester holds a word address until it is acknowledged. The arbiter issues one
//  memory read at a time, waits out the memory latency, and returns the tile code with a
//  one-cycle ack. Requesters therefore stall instead of assuming fixed read timing.
// PARAMETERS
//  ADDR_WIDTH     15  tilemap word address width
//  DATA_WIDTH     4   tile code width
//  MEM_LATENCY    1   cycles from address issue to valid mem_data; legal range 1..4
//  PRIORITY_MODE  0   0 = round-robin over ports 0,1,2
//                     1 = port 0 has fixed priority; ports 1,2 round-robin between themselves
// PORTS
//  clock        in   1           system clock, all state on posedge
//  resetn       in   1           asynchronous, active-low reset
//  req0..req2   in   1 each      read request; held high until the matching ack
//  addr0..addr2 in   ADDR_WIDTH  read address; held stable while the matching req is high
//  ack0..ack2   out  1 each      one-cycle pulse: rdata is valid for this port
//  rdata        out  DATA_WIDTH  returned tile code, shared bus; valid only while some ack is high
//  mem_address  out  ADDR_WIDTH  tilemap memory address
//  mem_rden     out  1           memory read strobe; high in the ISSUE cycle only
//  mem_data     in   DATA_WIDTH  tilemap memory read data
//  busy         out  1           high in ISSUE and WAIT
//  grant        out  2           index of the port being served (0..2); holds its last value in IDLE
// BEHAVIOUR
//  Reset values (asynchronous, resetn=0): state=IDLE, ack0..2=0, rdata=0, mem_address=0,
//  mem_rden=0, busy=0, grant=0, rr_ptr=2 (so port 0 is first in round-robin order),
//  wait_cnt=0.
//  States:
//   IDLE:  select a winner among ports whose req=1 and whose ack is not high this cycle.
//          If any -> register grant, go to ISSUE; else stay in IDLE.
//   ISSUE: mem_address=addr[grant], mem_rden=1, wait_cnt<=MEM_LATENCY-1; go to WAIT.
//   WAIT:  mem_address stays at addr[grant]. If wait_cnt==0 -> register rdata<=mem_data,
//          pulse ack[grant] next cycle, rr_ptr<=grant, go to IDLE. Else decrement wait_cnt.
//  Timing: req seen in IDLE at cycle T -> ISSUE at T+1 -> mem_data sampled at the end of
//   cycle T+1+MEM_LATENCY -> ack and rdata in cycle T+2+MEM_LATENCY (that cycle is IDLE).
//  Throughput: one access per MEM_LATENCY+2 cycles. A new winner may be picked in the
//   same cycle that an ack is high.
//  mem_address is driven to 0 in IDLE (never X).
//  Arbitration, PRIORITY_MODE=0: search order is rr_ptr+1, rr_ptr+2, rr_ptr (mod 3).
//  Arbitration, PRIORITY_MODE=1: req0 wins if eligible. Otherwise search 1,2 starting after
//   the last-served of {1,2}. rr_ptr is updated only on grants to ports 1 or 2.
//  Ack masking: a port whose ack is high this cycle is ineligible this cycle, so a requester
//   that drops req on the edge after its ack is never served twice.
//  Requester protocol violations:
//   - req dropped after grant: the access still completes and ack still pulses.
//   - addr changed after grant: the value sampled at ISSUE/WAIT is used; result undefined.
//  Reset mid-operation: the FSM returns to IDLE immediately. No ack is issued for the
//   aborted read. Pending requesters must re-arbitrate after reset release.
//  At most one ack is high in any cycle. ack and rdata are registered outputs.
// TESTING
//  1 MEM_LATENCY=1: req1=1, addr1=15'd2005 at cycle 0, memory returns 4'h3
//    -> mem_rden in cycle 1 only; ack1=1, rdata=4'h3 in cycle 3; ack1=0 otherwise.
//  2 Mode 0: req0..req2 all held high from reset release
//    -> grants in order 0,1,2,0,...; acks spaced 3 cycles apart; never two acks at once.
//  3 Mode 1: req0 re-asserted immediately after every ack, req1 and req2 held high
//    -> port 0 served on every slot; after req0 drops, service order is 1,2,1.
//  4 Requester drops req on the edge after its ack; only that requester requesting
//    -> exactly one ack; arbiter stays IDLE with mem_rden=0.
//  5 MEM_LATENCY=3: single req0, addr0=15'd7
//    -> mem_address=7 held for cycles 1-4; ack0 in cycle 5 with the value presented on
//       mem_data in cycle 4.
//  6 resetn pulsed low during WAIT
//    -> all outputs take reset values immediately; no ack follows; a held req is granted
//       again starting in the second cycle after release.

Source files
------------

// File: rtl/tilemap_read_arbiter.sv
// tilemap_read_arbiter: shares the tilemap read port among the
// background renderer and the two collision detectors.
module tilemap_read_arbiter #(
  parameter int ADDR_WIDTH    = 15,
  parameter int DATA_WIDTH    = 4,
  parameter int MEM_LATENCY   = 1,
  parameter int PRIORITY_MODE = 0
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  req2,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [ADDR_WIDTH-1:0] addr2,
  output logic                  ack0,
  output logic                  ack1,
  output logic                  ack2,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_rden,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  busy,
  output logic [1:0]            grant
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [1:0] LAT_M1 = 2'(MEM_LATENCY - 1);

  state_t     state;
  state_t     state_nxt;
  logic [2:0] req_v;
  logic [2:0] ack_q;
  logic [2:0] elig;
  logic [1:0] rr_ptr;
  logic [1:0] wait_cnt;
  logic [1:0] c1;
  logic [1:0] c2;
  logic [1:0] win;
  logic       found;

  function automatic logic [1:0] inc3(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign req_v = {req2, req1, req0};
  // a port acked this cycle must not win again on a stale req
  assign elig  = req_v & ~ack_q;
  assign c1    = inc3(rr_ptr);
  assign c2    = inc3(c1);
  assign {ack2, ack1, ack0} = ack_q;

  always_comb begin
    found = 1'b0;
    win   = 2'd0;
    if (PRIORITY_MODE == 1) begin
      if (elig[0]) begin
        found = 1'b1;
        win   = 2'd0;
      end else if (rr_ptr == 2'd1) begin
        if (elig[2]) begin
          found = 1'b1;
          win   = 2'd2;
        end else if (elig[1]) begin
          found = 1'b1;
          win   = 2'd1;
        end
      end else begin
        if (elig[1]) begin
          found = 1'b1;
          win   = 2'd1;
        end else if (elig[2]) begin
          found = 1'b1;
          win   = 2'd2;
        end
      end
    end else begin
      if (elig[c1]) begin
        found = 1'b1;
        win   = c1;
      end else if (elig[c2]) begin
        found = 1'b1;
        win   = c2;
      end else if (elig[rr_ptr]) begin
        found = 1'b1;
        win   = rr_ptr;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (found) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (wait_cnt == 2'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_rden    = (state == ISSUE);
    busy        = (state != IDLE);
    mem_address = '0;
    if (state != IDLE) begin
      unique case (grant)
        2'd0:    mem_address = addr0;
        2'd1:    mem_address = addr1;
        default: mem_address = addr2;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ack_q    <= '0;
      rdata    <= '0;
      grant    <= 2'd0;
      rr_ptr   <= 2'd2;
      wait_cnt <= 2'd0;
    end else begin
      ack_q <= '0;
      unique case (state)
        IDLE:  if (found) grant <= win;
        ISSUE: wait_cnt <= LAT_M1;
        WAIT: begin
          if (wait_cnt == 2'd0) begin
            rdata        <= mem_data;
            ack_q[grant] <= 1'b1;
            if (PRIORITY_MODE == 0 || grant != 2'd0) rr_ptr <= grant;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
